// File: rtl/s2_kes_ctrl_if.sv
// Handshake and data bundle between the stage-2 KES controller, the syndrome
// source, the key-equation solver and the Chien/Forney stage.
interface s2_kes_ctrl_if #(
   parameter int unsigned SYM_W = 8
);
   // syndrome input channel
   logic             syn_valid;
   logic             syn_ready;
   logic [SYM_W-1:0] syn0;
   logic [SYM_W-1:0] syn1;
   logic [SYM_W-1:0] syn2;
   logic [SYM_W-1:0] syn3;

   // solver channel
   logic             kes_ena;
   logic [SYM_W-1:0] kes_syn0;
   logic [SYM_W-1:0] kes_syn1;
   logic [SYM_W-1:0] kes_syn2;
   logic [SYM_W-1:0] kes_syn3;
   logic [SYM_W-1:0] kes_lambda0;
   logic [SYM_W-1:0] kes_lambda1;
   logic [SYM_W-1:0] kes_lambda2;
   logic [SYM_W-1:0] kes_omega0;
   logic [SYM_W-1:0] kes_omega1;
   logic             kes_done;

   // result channel
   logic             out_valid;
   logic             out_ready;
   logic [SYM_W-1:0] lambda0;
   logic [SYM_W-1:0] lambda1;
   logic [SYM_W-1:0] lambda2;
   logic [SYM_W-1:0] omega0;
   logic [SYM_W-1:0] omega1;
   logic [1:0]       out_nerr;
   logic             out_bypass;
   logic             out_fail;
   logic             busy;

   // controller side
   modport master (
      input  syn_valid, syn0, syn1, syn2, syn3,
      output syn_ready,
      output kes_ena, kes_syn0, kes_syn1, kes_syn2, kes_syn3,
      input  kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1, kes_done,
      output out_valid, lambda0, lambda1, lambda2, omega0, omega1,
      output out_nerr, out_bypass, out_fail, busy,
      input  out_ready
   );

   // environment side (syndrome source, solver, Chien stage)
   modport slave (
      output syn_valid, syn0, syn1, syn2, syn3,
      input  syn_ready,
      input  kes_ena, kes_syn0, kes_syn1, kes_syn2, kes_syn3,
      output kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1, kes_done,
      input  out_valid, lambda0, lambda1, lambda2, omega0, omega1,
      input  out_nerr, out_bypass, out_fail, busy,
      output out_ready
   );
endinterface

// File: rtl/s2_kes_ctrl.sv
// Stage-2 key-equation solver sequencer for the RS(t=2, GF(2^8)) decoder.
// Accepts syndromes, bypasses the solver on an all-zero syndrome set, otherwise
// launches the solver, waits for completion with a timeout, and registers the
// lambda/omega result plus status for the Chien/Forney stage.
module s2_kes_ctrl #(
   parameter int unsigned SYM_W   = 8,
   parameter int unsigned TIMEOUT = 8,
   parameter int unsigned CNT_W   = 4
) (
   input  logic          clk,
   input  logic          rstn,
   s2_kes_ctrl_if.master bus
);

   typedef enum logic [4:0] {
      IDLE   = 5'b00001,
      LAUNCH = 5'b00010,
      WAIT   = 5'b00100,
      HOLD   = 5'b01000,
      BYP    = 5'b10000
   } state_t;

   typedef enum logic [1:0] {
      LD_CAP  = 2'd0,
      LD_FAIL = 2'd1,
      LD_BYP  = 2'd2
   } ld_sel_t;

   state_t           state;
   logic [CNT_W-1:0] tmo_cnt;
   logic             hold_fail;
   logic             out_free;
   logic             tmo_last;
   logic             syn_zero;
   logic             ld;
   ld_sel_t          ld_sel;
   logic [1:0]       cap_nerr;

   assign out_free = !bus.out_valid || bus.out_ready;
   assign tmo_last = (tmo_cnt == CNT_W'(TIMEOUT - 1));
   assign syn_zero = (bus.syn0 == '0) && (bus.syn1 == '0) &&
                     (bus.syn2 == '0) && (bus.syn3 == '0);
   assign bus.busy = (state != IDLE);

   // Error-count estimate from the degree of the solver's lambda
   always_comb begin
      cap_nerr = 2'd0;
      if (bus.kes_lambda2 != '0)
         cap_nerr = 2'd2;
      else if (bus.kes_lambda1 != '0)
         cap_nerr = 2'd1;
   end

   // Decide whether the output register is loaded this cycle and with what;
   // kes_done takes priority over an expiring timeout
   always_comb begin
      ld     = 1'b0;
      ld_sel = LD_CAP;
      case (state)
         WAIT: begin
            if (bus.kes_done) begin
               ld     = out_free;
               ld_sel = LD_CAP;
            end else if (tmo_last) begin
               ld     = out_free;
               ld_sel = LD_FAIL;
            end
         end
         HOLD: begin
            ld     = out_free;
            ld_sel = hold_fail ? LD_FAIL : LD_CAP;
         end
         BYP: begin
            ld     = out_free;
            ld_sel = LD_BYP;
         end
         default: ;
      endcase
   end

   // Sequencer state, solver launch, syndrome latch and output register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= IDLE;
         tmo_cnt        <= '0;
         hold_fail      <= 1'b0;
         bus.syn_ready  <= 1'b0;
         bus.kes_ena    <= 1'b0;
         bus.kes_syn0   <= '0;
         bus.kes_syn1   <= '0;
         bus.kes_syn2   <= '0;
         bus.kes_syn3   <= '0;
         bus.out_valid  <= 1'b0;
         bus.lambda0    <= '0;
         bus.lambda1    <= '0;
         bus.lambda2    <= '0;
         bus.omega0     <= '0;
         bus.omega1     <= '0;
         bus.out_nerr   <= 2'd0;
         bus.out_bypass <= 1'b0;
         bus.out_fail   <= 1'b0;
      end else begin
         bus.kes_ena <= 1'b0;

         case (state)
            IDLE: begin
               bus.syn_ready <= 1'b1;
               if (bus.syn_ready && bus.syn_valid) begin
                  bus.syn_ready <= 1'b0;
                  bus.kes_syn0  <= bus.syn0;
                  bus.kes_syn1  <= bus.syn1;
                  bus.kes_syn2  <= bus.syn2;
                  bus.kes_syn3  <= bus.syn3;
                  if (syn_zero) begin
                     state <= BYP;
                  end else begin
                     state       <= LAUNCH;
                     bus.kes_ena <= 1'b1;
                  end
               end
            end
            LAUNCH: begin
               tmo_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (bus.kes_done || tmo_last) begin
                  hold_fail <= !bus.kes_done;
                  state     <= ld ? IDLE : HOLD;
               end
            end
            HOLD, BYP: begin
               if (ld)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // syn_ready must already be high in the cycle after a load
         if (ld)
            bus.syn_ready <= 1'b1;

         if (ld) begin
            bus.out_valid <= 1'b1;
            case (ld_sel)
               LD_CAP: begin
                  bus.lambda0    <= bus.kes_lambda0;
                  bus.lambda1    <= bus.kes_lambda1;
                  bus.lambda2    <= bus.kes_lambda2;
                  bus.omega0     <= bus.kes_omega0;
                  bus.omega1     <= bus.kes_omega1;
                  bus.out_nerr   <= cap_nerr;
                  bus.out_fail   <= (cap_nerr == 2'd0);
                  bus.out_bypass <= 1'b0;
               end
               LD_BYP: begin
                  bus.lambda0    <= SYM_W'(1);
                  bus.lambda1    <= '0;
                  bus.lambda2    <= '0;
                  bus.omega0     <= '0;
                  bus.omega1     <= '0;
                  bus.out_nerr   <= 2'd0;
                  bus.out_fail   <= 1'b0;
                  bus.out_bypass <= 1'b1;
               end
               default: begin
                  bus.lambda0    <= '0;
                  bus.lambda1    <= '0;
                  bus.lambda2    <= '0;
                  bus.omega0     <= '0;
                  bus.omega1     <= '0;
                  bus.out_nerr   <= 2'd0;
                  bus.out_fail   <= 1'b1;
                  bus.out_bypass <= 1'b0;
               end
            endcase
         end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_s2_kes_ctrl.sv
// Directed bench for s2_kes_ctrl: reset, bypass, nominal solve, backpressure,
// timeout, uncorrectable result and reset during a solve.
module tb_s2_kes_ctrl;

   logic clk;
   logic rstn;
   int   checks   = 0;
   int   failures = 0;
   int   ena_cnt  = 0;
   int   ena_ref  = 0;

   s2_kes_ctrl_if #(.SYM_W(8)) bus ();

   s2_kes_ctrl #(
      .SYM_W   (8),
      .TIMEOUT (8),
      .CNT_W   (4)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count cycles in which the solver launch strobe is high
   always @(posedge clk) begin
      if (bus.kes_ena)
         ena_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_syn(input logic [7:0] s0, input logic [7:0] s1,
                          input logic [7:0] s2, input logic [7:0] s3);
      bus.syn0 = s0;
      bus.syn1 = s1;
      bus.syn2 = s2;
      bus.syn3 = s3;
   endtask

   task automatic set_kes(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                          input logic [7:0] o0, input logic [7:0] o1);
      bus.kes_lambda0 = l0;
      bus.kes_lambda1 = l1;
      bus.kes_lambda2 = l2;
      bus.kes_omega0  = o0;
      bus.kes_omega1  = o1;
   endtask

   initial begin
      rstn          = 1'b0;
      bus.syn_valid = 1'b0;
      bus.kes_done  = 1'b0;
      bus.out_ready = 1'b0;
      set_syn(8'h00, 8'h00, 8'h00, 8'h00);
      set_kes(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

      // reset
      repeat (3) tick();
      chk("rst_syn_ready", 32'(bus.syn_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_kes_ena",   32'(bus.kes_ena),   32'd0);
      chk("rst_lambda0",   32'(bus.lambda0),   32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      rstn = 1'b1;
      tick();
      chk("rel_syn_ready", 32'(bus.syn_ready), 32'd1);

      // bypass
      ena_ref = ena_cnt;
      bus.syn_valid = 1'b1;
      tick();
      bus.syn_valid = 1'b0;
      chk("byp_syn_ready", 32'(bus.syn_ready), 32'd0);
      chk("byp_busy",      32'(bus.busy),      32'd1);
      chk("byp_kes_ena",   32'(bus.kes_ena),   32'd0);
      chk("byp_t1_valid",  32'(bus.out_valid), 32'd0);
      tick();
      chk("byp_t2_valid",  32'(bus.out_valid),  32'd1);
      chk("byp_lambda0",   32'(bus.lambda0),    32'h01);
      chk("byp_lambda1",   32'(bus.lambda1),    32'h00);
      chk("byp_lambda2",   32'(bus.lambda2),    32'h00);
      chk("byp_bypass",    32'(bus.out_bypass), 32'd1);
      chk("byp_nerr",      32'(bus.out_nerr),   32'd0);
      chk("byp_fail",      32'(bus.out_fail),   32'd0);
      chk("byp_no_launch", 32'(ena_cnt),        32'(ena_ref));
      bus.out_ready = 1'b1;
      tick();
      chk("byp_drained",   32'(bus.out_valid),  32'd0);

      // nominal solve
      bus.out_ready = 1'b0;
      ena_ref = ena_cnt;
      set_syn(8'h12, 8'h34, 8'h56, 8'h78);
      bus.syn_valid = 1'b1;
      tick();
      bus.syn_valid = 1'b0;
      chk("nom_ena_launch", 32'(bus.kes_ena),  32'd1);
      chk("nom_kes_syn0",   32'(bus.kes_syn0), 32'h12);
      chk("nom_kes_syn3",   32'(bus.kes_syn3), 32'h78);
      tick();
      chk("nom_ena_after",  32'(bus.kes_ena),  32'd0);
      repeat (3) tick();
      chk("nom_t5_valid",   32'(bus.out_valid), 32'd0);
      set_kes(8'h01, 8'hA3, 8'h5C, 8'h11, 8'h22);
      bus.kes_done = 1'b1;
      tick();
      bus.kes_done = 1'b0;
      chk("nom_t6_valid",   32'(bus.out_valid),  32'd1);
      chk("nom_lambda0",    32'(bus.lambda0),    32'h01);
      chk("nom_lambda1",    32'(bus.lambda1),    32'hA3);
      chk("nom_lambda2",    32'(bus.lambda2),    32'h5C);
      chk("nom_omega0",     32'(bus.omega0),     32'h11);
      chk("nom_omega1",     32'(bus.omega1),     32'h22);
      chk("nom_nerr",       32'(bus.out_nerr),   32'd2);
      chk("nom_fail",       32'(bus.out_fail),   32'd0);
      chk("nom_bypass",     32'(bus.out_bypass), 32'd0);
      chk("nom_one_launch", 32'(ena_cnt),        32'(ena_ref + 1));
      chk("nom_syn_ready",  32'(bus.syn_ready),  32'd1);

      // backpressure: previous result still pending when the solver finishes
      set_syn(8'h01, 8'h02, 8'h03, 8'h04);
      bus.syn_valid = 1'b1;
      tick();
      bus.syn_valid = 1'b0;
      chk("bp_kes_syn1",    32'(bus.kes_syn1),  32'h02);
      chk("bp_old_held",    32'(bus.lambda1),   32'hA3);
      repeat (4) tick();
      set_kes(8'h01, 8'h0F, 8'h00, 8'h33, 8'h44);
      bus.kes_done = 1'b1;
      tick();
      bus.kes_done = 1'b0;
      chk("bp_hold_ready",  32'(bus.syn_ready), 32'd0);
      chk("bp_hold_busy",   32'(bus.busy),      32'd1);
      chk("bp_hold_valid",  32'(bus.out_valid), 32'd1);
      chk("bp_hold_old",    32'(bus.lambda1),   32'hA3);
      repeat (2) tick();
      chk("bp_hold_old2",   32'(bus.lambda1),   32'hA3);
      bus.out_ready = 1'b1;
      tick();
      chk("bp_load_valid",  32'(bus.out_valid), 32'd1);
      chk("bp_load_l1",     32'(bus.lambda1),   32'h0F);
      chk("bp_load_l2",     32'(bus.lambda2),   32'h00);
      chk("bp_load_o0",     32'(bus.omega0),    32'h33);
      chk("bp_load_nerr",   32'(bus.out_nerr),  32'd1);
      chk("bp_load_fail",   32'(bus.out_fail),  32'd0);
      chk("bp_load_ready",  32'(bus.syn_ready), 32'd1);
      tick();
      chk("bp_no_dup",      32'(bus.out_valid), 32'd0);

      // timeout
      ena_ref = ena_cnt;
      set_syn(8'hAA, 8'h00, 8'h00, 8'h00);
      bus.syn_valid = 1'b1;
      tick();
      bus.syn_valid = 1'b0;
      repeat (8) tick();
      chk("tmo_last_wait",  32'(bus.out_valid), 32'd0);
      chk("tmo_busy",       32'(bus.busy),      32'd1);
      tick();
      chk("tmo_valid",      32'(bus.out_valid), 32'd1);
      chk("tmo_fail",       32'(bus.out_fail),  32'd1);
      chk("tmo_lambda0",    32'(bus.lambda0),   32'h00);
      chk("tmo_lambda1",    32'(bus.lambda1),   32'h00);
      chk("tmo_omega0",     32'(bus.omega0),    32'h00);
      chk("tmo_nerr",       32'(bus.out_nerr),  32'd0);
      chk("tmo_syn_ready",  32'(bus.syn_ready), 32'd1);
      chk("tmo_one_launch", 32'(ena_cnt),       32'(ena_ref + 1));

      // uncorrectable: degree-0 lambda with non-zero syndromes
      set_syn(8'h05, 8'h06, 8'h07, 8'h08);
      set_kes(8'h01, 8'h00, 8'h00, 8'h09, 8'h0A);
      bus.syn_valid = 1'b1;
      tick();
      bus.syn_valid = 1'b0;
      chk("unc_drained",    32'(bus.out_valid), 32'd0);
      repeat (4) tick();
      bus.kes_done = 1'b1;
      tick();
      bus.kes_done = 1'b0;
      chk("unc_valid",      32'(bus.out_valid),  32'd1);
      chk("unc_fail",       32'(bus.out_fail),   32'd1);
      chk("unc_nerr",       32'(bus.out_nerr),   32'd0);
      chk("unc_lambda0",    32'(bus.lambda0),    32'h01);
      chk("unc_omega0",     32'(bus.omega0),     32'h09);
      chk("unc_bypass",     32'(bus.out_bypass), 32'd0);

      // reset in the middle of a solve
      set_syn(8'h11, 8'h22, 8'h33, 8'h44);
      bus.syn_valid = 1'b1;
      tick();
      bus.syn_valid = 1'b0;
      repeat (2) tick();
      ena_ref = ena_cnt;
      #2 rstn = 1'b0;
      #1;
      chk("mrst_valid",     32'(bus.out_valid), 32'd0);
      chk("mrst_ready",     32'(bus.syn_ready), 32'd0);
      chk("mrst_busy",      32'(bus.busy),      32'd0);
      chk("mrst_kes_ena",   32'(bus.kes_ena),   32'd0);
      chk("mrst_kes_syn0",  32'(bus.kes_syn0),  32'h00);
      chk("mrst_lambda0",   32'(bus.lambda0),   32'h00);
      rstn = 1'b1;
      tick();
      chk("mrst_rel_ready", 32'(bus.syn_ready), 32'd1);
      repeat (3) tick();
      chk("mrst_no_launch", 32'(ena_cnt),       32'(ena_ref));
      chk("mrst_idle_valid", 32'(bus.out_valid), 32'd0);
      chk("mrst_idle_busy", 32'(bus.busy),      32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
